// File: rtl/dmem_responder_pkg.sv
// Shared constants, request payload and address check for the data-memory responder.
package dmem_responder_pkg;

  localparam int unsigned INST_SIZE    = 32;
  localparam int unsigned DMEM_BE_SIZE = 4;
  localparam int unsigned DMEM_CNT_W   = 4;

  localparam logic [1:0] DMEM_IDLE = 2'd0;
  localparam logic [1:0] DMEM_WAIT = 2'd1;
  localparam logic [1:0] DMEM_RESP = 2'd2;

  typedef struct packed {
    logic                    we;
    logic [INST_SIZE-1:0]    addr;
    logic [INST_SIZE-1:0]    wdata;
    logic [DMEM_BE_SIZE-1:0] be;
  } dmem_req_t;

  // Misaligned byte address, or word index beyond a 2^aw-word array.
  function automatic logic dmem_addr_err(input logic [INST_SIZE-1:0] addr, input int unsigned aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 32'd2)) != '0);
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Synchronous single-port word RAM with per-byte write enables and registered read data.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DMEM_BE_SIZE-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [INST_SIZE-1:0]    wdata,
  output logic [INST_SIZE-1:0]    rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [INST_SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(DMEM_BE_SIZE); i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, holds it LATENCY edges, returns a one-cycle response.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [INST_SIZE-1:0]    req_addr,
  input  logic [INST_SIZE-1:0]    req_wdata,
  input  logic [DMEM_BE_SIZE-1:0] req_be,
  output logic                    rsp_valid,
  output logic [INST_SIZE-1:0]    rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = DMEM_CNT_W'(LATENCY - 32'd1);
  localparam logic [DMEM_CNT_W-1:0] CNT_LAST = DMEM_CNT_W'(1);
  localparam bit                    SINGLE   = (LATENCY == 32'd1);

  logic [1:0]            state, state_nxt;
  logic [DMEM_CNT_W-1:0] cnt, cnt_nxt;
  dmem_req_t             held;
  dmem_req_t             acc_req;
  logic                  accept;
  logic                  access;
  logic                  acc_err;
  logic                  rsp_load;
  logic [INST_SIZE-1:0]  arr_rdata;

  assign req_ready = (state != DMEM_WAIT);
  assign accept    = req_valid && req_ready;
  // Stall must rise in the accept cycle itself, hence combinational.
  assign busy      = (state == DMEM_WAIT) || ((state == DMEM_IDLE) && req_valid && !SINGLE);

  // With LATENCY 1 the access edge is the accept edge, so the live request goes straight to the array.
  always_comb begin
    acc_req = held;
    if (state != DMEM_WAIT) begin
      acc_req.we    = req_we;
      acc_req.addr  = req_addr;
      acc_req.wdata = req_wdata;
      acc_req.be    = req_be;
    end
  end

  assign access  = ((state == DMEM_WAIT) && (cnt == CNT_LAST)) || (accept && SINGLE);
  assign acc_err = dmem_addr_err(acc_req.addr, ADDR_WIDTH);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      DMEM_IDLE, DMEM_RESP: begin
        if (accept) begin
          state_nxt = SINGLE ? DMEM_RESP : DMEM_WAIT;
          cnt_nxt   = CNT_LOAD;
        end else begin
          state_nxt = DMEM_IDLE;
        end
      end
      DMEM_WAIT: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_LAST) state_nxt = DMEM_RESP;
      end
      default: state_nxt = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DMEM_IDLE;
      cnt       <= '0;
      held      <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_load  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      if (accept) held <= acc_req;
      rsp_valid <= access;
      rsp_err   <= access && acc_err;
      rsp_load  <= access && !acc_req.we && !acc_err;
    end
  end

  // Array data is registered on the access edge; only a good load lets it through.
  assign rsp_rdata = rsp_load ? arr_rdata : '0;

  dmem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (access && acc_req.we && !acc_err),
    .be   (acc_req.be),
    .addr (acc_req.addr[ADDR_WIDTH+1:2]),
    .wdata(acc_req.wdata),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances with LATENCY 1..4, each driven by directed and random traffic.
module tb_dmem_responder;

  logic clk = 1'b0;
  int   edges  = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  task automatic chk(input int lat, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL L=%0d %s: got %h expected %h (t=%0t)", lat, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : inst
    localparam int L = g + 1;

    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    dmem_responder #(
      .ADDR_WIDTH(10),
      .LATENCY   (L)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we   (req_we),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .req_be   (req_be),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err),
      .busy     (busy)
    );

    // Model: word store for words 0..15 plus the one outstanding request and its accept edge.
    logic [31:0] mm [16];
    bit          have = 1'b0;
    int          t_acc = 0;
    logic        p_we;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_be;
    logic [31:0] last_rdata;
    logic        last_err;

    // One clock cycle: drive at the falling edge, check every output, then update the model.
    task automatic cyc(input logic r, input logic v, input bit junk, input logic we,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       output bit acc);
      int          e, w;
      bit          waiting, resp, eerr;
      logic [31:0] erd;
      @(negedge clk);
      e       = edges + 1;
      waiting = have && (e < t_acc + L);
      resp    = have && (e == t_acc + L);
      rst       = r;
      req_valid = (junk ? waiting : v) && !r;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      req_be    = be;
      #1;
      eerr = 1'b0;
      erd  = '0;
      if (resp) begin
        eerr = (p_addr[1:0] != 2'b00) || (p_addr[31:2] >= 30'd1024);
        w    = int'(p_addr[5:2]);
        if (!eerr && !p_we) erd = mm[w];
        if (!eerr && p_we) begin
          for (int b = 0; b < 4; b++) if (p_be[b]) mm[w][8*b +: 8] = p_wdata[8*b +: 8];
        end
        have = 1'b0;
        if (!r) begin
          last_rdata = rsp_rdata;
          last_err   = rsp_err;
        end
      end
      if (r) have = 1'b0;
      chk(L, "req_ready", 32'(req_ready), 32'(r || !waiting));
      chk(L, "busy", 32'(busy), 32'(!r && (waiting || (!resp && req_valid && (L > 1)))));
      chk(L, "rsp_valid", 32'(rsp_valid), 32'(resp && !r));
      chk(L, "rsp_err", 32'(rsp_err), 32'(resp && !r && eerr));
      chk(L, "rsp_rdata", rsp_rdata, (resp && !r) ? erd : 32'h0);
      acc = req_valid && !waiting;
      if (acc) begin
        have    = 1'b1;
        t_acc   = e;
        p_we    = we;
        p_addr  = a;
        p_wdata = d;
        p_be    = be;
      end
    endtask

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      bit acc;
      acc = 1'b0;
      for (int i = 0; i < 40 && !acc; i++) cyc(1'b0, 1'b1, 1'b0, we, a, d, be, acc);
      if (!acc) chk(L, "accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom), acc);
    endtask

    // Scramble the request inputs with req_valid high, but only while a request is in flight.
    task automatic junk(input int n);
      bit acc;
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1, 1'($urandom), $urandom, $urandom, 4'($urandom), acc);
    endtask

    task automatic do_reset();
      bit acc;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, acc);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, acc);
    endtask

    initial begin
      int          sel;
      logic [31:0] a;
      bit          acc;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, acc);
      do_reset();

      for (int i = 0; i < 16; i++)
        issue(1'b1, 32'(i) << 2, (i == 4) ? 32'h0 : 32'hA500_0000 + 32'(i), 4'hF);

      // Partial store then load of the same word.
      issue(1'b1, 32'h10, 32'h1122_3344, 4'b0101);
      issue(1'b0, 32'h10, 32'h0, 4'h0);
      idle(L + 1);
      chk(L, "lit_partial_store", last_rdata, 32'h0022_0044);

      // Reset right after a store is accepted: abandoned unless the access edge already passed.
      issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
      do_reset();
      issue(1'b0, 32'h10, 32'h0, 4'h0);
      idle(L + 1);
      chk(L, "lit_reset_abort", last_rdata, (L == 1) ? 32'hDEAD_BEEF : 32'h0022_0044);

      // Back-to-back loads with req_valid held.
      for (int i = 0; i < 4; i++) issue(1'b0, 32'(i) << 2, 32'h0, 4'h0);
      idle(L + 1);
      chk(L, "lit_b2b_last", last_rdata, 32'hA500_0003);

      // Misaligned load, then out-of-range store that must leave word 0 alone.
      issue(1'b0, 32'h6, 32'h0, 4'h0);
      idle(L + 1);
      chk(L, "lit_misalign_err", 32'(last_err), 32'd1);
      chk(L, "lit_misalign_rdata", last_rdata, 32'h0);
      issue(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF);
      idle(L + 1);
      chk(L, "lit_range_err", 32'(last_err), 32'd1);
      issue(1'b0, 32'h0, 32'h0, 4'h0);
      idle(L + 1);
      chk(L, "lit_range_word0", last_rdata, 32'hA500_0000);

      // Request inputs scrambled while waiting.
      issue(1'b0, 32'h8, 32'h0, 4'h0);
      junk(3);
      idle(L + 1);
      chk(L, "lit_wait_changes", last_rdata, 32'hA500_0002);

      for (int k = 0; k < 200; k++) begin
        sel = int'($urandom_range(0, 9));
        if (sel < 8)       a = 32'($urandom_range(0, 15)) << 2;
        else if (sel == 8) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        else               a = $urandom | 32'h0000_1000;
        issue(1'($urandom), a, $urandom, 4'($urandom));
        junk(int'($urandom_range(0, L)));
        idle(int'($urandom_range(0, 1)));
        if ($urandom_range(0, 39) == 0) do_reset();
      end
      idle(L + 1);
      n_done++;
    end
  end

  initial begin
    for (int i = 0; i < 60000 && n_done < 4; i++) @(posedge clk);
    chk(0, "all_instances_done", 32'(n_done), 32'd4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
